pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards, applies flushes for taken branches and jumps, freezes the pipe on memory stalls, and latches HALT on an exception.
//  Drives the write-enable and flush (bubble) controls of every pipeline register.
//  Sits between the decode/EX/MEM stage outputs and the pipe register flops.
// PARAMETERS
//  REG_BITS  3   register-specifier width (8 GPRs)
//  CNT_W     16  stall-cycle counter width
// PORTS
//  clk           in   1         system clock; all state changes on rising edge
//  rst           in   1         asynchronous, active-high reset
//  id_rs         in   REG_BITS  Rs specifier of instruction in ID
//  id_rt         in   REG_BITS  Rt specifier of instruction in ID
//  id_rs_used    in   1         ID instruction reads Rs
//  id_rt_used    in   1         ID instruction reads Rt
//  ex_rd         in   REG_BITS  destination register of instruction in EX
//  ex_mem_read   in   1         EX instruction is a load
//  ex_reg_write  in   1         EX instruction writes a register
//  br_taken      in   1         EX resolved a taken branch or jump this cycle
//  mem_stall     in   1         instruction or data memory not ready this cycle
//  excp          in   1         EX instruction is HALT or raises an exception
//  pc_we         out  1         PC write enable
//  ifid_we       out  1         IF/ID register write enable
//  ifid_flush    out  1         IF/ID loads a NOP
//  idex_we       out  1         ID/EX register write enable
//  idex_flush    out  1         ID/EX loads all-zero controls (bubble)
//  exmem_we      out  1         EX/MEM register write enable
//  memwb_we      out  1         MEM/WB register write enable
//  halted        out  1         pipeline halted; sticky
//  stall_cnt     out  CNT_W     saturating count of cycles with pc_we=0, excluding HALT
// BEHAVIOUR
//  States: RUN, LD_STALL, MEM_WAIT, HALT. ret_state is a 1-bit register (RUN or LD_STALL).
//  rst asserted:
//   - state=RUN, ret_state=RUN, stall_cnt=0.
//   - All enable and flush outputs are 0; halted=0.
//  Outputs are decoded combinationally from the current state and current inputs.
//  "All enables" means pc_we, ifid_we, idex_we, exmem_we and memwb_we.
//  Load-use hazard:
//   lu = ex_mem_read & ex_reg_write & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
//  Priority, evaluated each cycle: HALT state > excp > mem_stall > br_taken > lu.
//  RUN:
//   - excp: memwb_we=1; all other enables 0; next state HALT.
//   - else mem_stall: all enables 0, flushes 0; ret_state<=RUN; next state MEM_WAIT.
//   - else br_taken: all enables 1, ifid_flush=1, idex_flush=1; next state RUN.
//     A taken branch outranks lu; the flush removes the dependent instruction.
//   - else lu: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem_we=1, memwb_we=1; next state LD_STALL.
//   - else: all enables 1, flushes 0; stay in RUN.
//  LD_STALL (exactly one bubble has been inserted):
//   - All enables 1; lu is ignored.
//   - excp, mem_stall and br_taken are handled as in RUN.
//   - mem_stall sets ret_state<=LD_STALL.
//   - Otherwise next state RUN.
//  MEM_WAIT:
//   - While mem_stall=1: all enables 0; stay in MEM_WAIT.
//   - excp has no effect while frozen.
//   - On the first cycle with mem_stall=0: evaluate as if in ret_state, including excp, br_taken and lu.
//  HALT: all enables 0, flushes 0, halted=1. Only rst leaves HALT.
//  stall_cnt:
//   - Increments on each rising edge where pc_we=0 and the state is not HALT.
//   - Saturates at 2^CNT_W-1.
//   - The cycle that enters HALT is not counted.
//  ifid_flush and idex_flush are only ever asserted together with their matching enable.
//  No output asserts a flush while its register's enable is 0.
// TESTING
//  1. Load to r3 in EX, ID reads r3 as Rs (id_rs_used=1) -> one cycle with pc_we=0 and idex_flush=1; next cycle all enables 1; stall_cnt=1.
//  2. Load to r3 in EX, ID reads r3 but id_rs_used=0 and id_rt_used=0 -> no stall; all enables stay 1.
//  3. br_taken and lu in the same cycle -> ifid_flush=1, idex_flush=1, pc_we=1; no LD_STALL entered; stall_cnt unchanged.
//  4. mem_stall for 4 cycles while in LD_STALL -> 4 cycles of all enables 0; the next cycle behaves as LD_STALL; stall_cnt +4.
//  5. excp in RUN -> memwb_we=1 that cycle, then halted=1 forever; an asynchronous rst mid-HALT clears all outputs immediately, before the next clock edge.
//  6. Hold mem_stall for 2^CNT_W+5 cycles -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for a 5-stage pipe: load-use bubbles, branch flushes,
// memory-stall freezes and sticky HALT, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int REG_BITS = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rs_used,
   input  logic                id_rt_used,
   input  logic [REG_BITS-1:0] ex_rd,
   input  logic                ex_mem_read,
   input  logic                ex_reg_write,
   input  logic                br_taken,
   input  logic                mem_stall,
   input  logic                excp,
   output logic                pc_we,
   output logic                ifid_we,
   output logic                ifid_flush,
   output logic                idex_we,
   output logic                idex_flush,
   output logic                exmem_we,
   output logic                memwb_we,
   output logic                halted,
   output logic [CNT_W-1:0]    stall_cnt
);

   typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, HALT} state_t;

   state_t state, next_state;
   logic   ret_ld;        // return state after MEM_WAIT: 1 = LD_STALL, 0 = RUN
   logic   ret_load;
   logic   ret_ld_next;
   logic   lu;
   logic   active;
   logic   from_ld;
   logic   cnt_en;

   assign lu = ex_mem_read & ex_reg_write &
               ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_we     = 1'b0;
      idex_flush  = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      halted      = 1'b0;
      next_state  = state;
      ret_load    = 1'b0;
      ret_ld_next = ret_ld;

      // MEM_WAIT with memory ready behaves exactly like the state it froze in.
      active  = (state == RUN) || (state == LD_STALL) || (state == MEM_WAIT && !mem_stall);
      from_ld = (state == LD_STALL) || (state == MEM_WAIT && ret_ld);

      if (!rst && active) begin
         if (excp) begin
            memwb_we   = 1'b1;
            next_state = HALT;
         end else if (mem_stall) begin
            ret_load    = 1'b1;
            ret_ld_next = from_ld;
            next_state  = MEM_WAIT;
         end else if (br_taken) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            next_state = RUN;
         end else if (lu && !from_ld) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            next_state = LD_STALL;
         end else begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            next_state = RUN;
         end
      end

      if (!rst && state == HALT) halted = 1'b1;
   end

   // The edge that moves into HALT is excluded from the stall count.
   assign cnt_en = !pc_we && (state != HALT) && (next_state != HALT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         ret_ld    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state <= next_state;
         if (ret_load) ret_ld <= ret_ld_next;
         if (cnt_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

   localparam int REG_BITS = 3;
   localparam int CNT_W    = 16;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   // Expected output vectors: {pc, ifid, ifid_fl, idex, idex_fl, exmem, memwb, halted}
   localparam logic [7:0] V_GO     = 8'b1101_0110;
   localparam logic [7:0] V_FLUSH  = 8'b1111_1110;
   localparam logic [7:0] V_BUBBLE = 8'b0001_1110;
   localparam logic [7:0] V_LAST   = 8'b0000_0010;
   localparam logic [7:0] V_HALT   = 8'b0000_0001;
   localparam logic [7:0] V_OFF    = 8'b0000_0000;

   logic                clk = 1'b0;
   logic                rst;
   logic [REG_BITS-1:0] id_rs, id_rt, ex_rd;
   logic                id_rs_used, id_rt_used, ex_mem_read, ex_reg_write;
   logic                br_taken, mem_stall, excp;
   logic                pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
   logic                exmem_we, memwb_we, halted;
   logic [CNT_W-1:0]    stall_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .br_taken(br_taken), .mem_stall(mem_stall), .excp(excp),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
      .memwb_we(memwb_we), .halted(halted), .stall_cnt(stall_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Model: pipe is halted, frozen waiting on memory, or just inserted a bubble.
   bit m_halted, m_frozen, m_bubble;
   int m_cnt;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, halted};
   endfunction

   task automatic set_in(input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic [2:0] rd, input logic ld,
                         input logic wr, input logic br, input logic ms, input logic ex);
      id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu; ex_rd = rd;
      ex_mem_read = ld; ex_reg_write = wr; br_taken = br; mem_stall = ms; excp = ex;
   endtask

   // Called at a falling edge with inputs already driven; checks and advances one cycle.
   task automatic step(string tag);
      logic [7:0] e;
      bit uses_load, counts;
      bit n_halted = m_halted, n_frozen = m_frozen, n_bubble = m_bubble;
      uses_load = ex_mem_read && ex_reg_write &&
                  ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
      counts = 1'b0;
      if (m_halted) begin
         e = V_HALT;
      end else if (m_frozen && mem_stall) begin
         e = V_OFF; counts = 1'b1;
      end else if (excp) begin
         e = V_LAST; n_halted = 1'b1;
      end else if (mem_stall) begin
         e = V_OFF; counts = 1'b1; n_frozen = 1'b1;
      end else if (br_taken) begin
         e = V_FLUSH; n_frozen = 1'b0; n_bubble = 1'b0;
      end else if (uses_load && !m_bubble) begin
         e = V_BUBBLE; counts = 1'b1; n_frozen = 1'b0; n_bubble = 1'b1;
      end else begin
         e = V_GO; n_frozen = 1'b0; n_bubble = 1'b0;
      end
      #1;
      check(tag, outs(), e);
      check({tag, ".cnt"}, stall_cnt, m_cnt);
      @(posedge clk);
      if (counts && m_cnt < CNT_MAX) m_cnt++;
      m_halted = n_halted; m_frozen = n_frozen; m_bubble = n_bubble;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset.outs", outs(), V_OFF);
      check("reset.cnt", stall_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      m_halted = 0; m_frozen = 0; m_bubble = 0; m_cnt = 0;
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // Load-use on Rs: one bubble, then LD_STALL lets everything move.
      set_in(3, 1, 0, 0, 3, 1, 1, 0, 0, 0);
      step("t1.bubble");
      step("t1.resume");
      #1 check("t1.cnt_is_1", stall_cnt, 1);

      // Same registers but neither specifier is read: no hazard.
      do_reset();
      set_in(3, 0, 3, 0, 3, 1, 1, 0, 0, 0);
      step("t2.norun0");
      step("t2.norun1");
      #1 check("t2.cnt_is_0", stall_cnt, 0);

      // Taken branch wins over load-use.
      set_in(3, 1, 3, 1, 3, 1, 1, 1, 0, 0);
      step("t3.flush");
      set_in(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
      step("t3.after");
      #1 check("t3.cnt_is_0", stall_cnt, 0);

      // Memory stall while in LD_STALL: four frozen cycles, then LD_STALL resumes.
      do_reset();
      set_in(1, 0, 6, 1, 6, 1, 1, 0, 0, 0);
      step("t4.bubble");
      set_in(1, 0, 6, 1, 6, 1, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step("t4.frozen");
      set_in(1, 0, 6, 1, 6, 1, 1, 0, 0, 0);
      step("t4.ldstall");
      #1 check("t4.cnt_is_5", stall_cnt, 5);

      // Exception: final MEM/WB write, then sticky HALT; async reset clears at once.
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("t5.excp");
      set_in(2, 1, 2, 1, 2, 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step("t5.halt");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("t5.async_outs", outs(), V_OFF);
      check("t5.async_cnt", stall_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      m_halted = 0; m_frozen = 0; m_bubble = 0; m_cnt = 0;
      step("t5.run_again");

      // Counter saturation under a very long memory stall.
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < CNT_MAX + 6; i++) step("t6.stall");
      #1 check("t6.saturated", stall_cnt, CNT_MAX);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("t6.release");

      // Randomized traffic with biased register matches.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic [2:0] rd;
         if (m_halted && $urandom_range(0, 7) == 0) do_reset();
         rd = 3'($urandom_range(0, 7));
         set_in(($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                rd,
                1'($urandom_range(0, 99) < 60),
                1'($urandom_range(0, 99) < 80),
                1'($urandom_range(0, 99) < 15),
                1'($urandom_range(0, 99) < 20),
                1'($urandom_range(0, 99) < 2));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
